// File: rtl/pwm_axil_regs.sv
// pwm_axil_regs: AXI4-Lite register window for the PWM core, plus the
// counter/comparator that the registers drive.
//   ACLK, ARESET     clock, synchronous active-high reset
//   S_AXI_AW*/W*/B*  write address / data / response channels
//   S_AXI_AR*/R*     read address / data channels
//   PWM_OUT          registered PWM output
// Register map (addr[3:2]): 0 CTRL (bit0 EN, bit1 POL), 1 PERIOD, 2 DUTY, 3 SCRATCH.
// PERIOD and DUTY go through shadow registers that reload only at a period
// boundary, or continuously while the PWM is disabled.
module pwm_axil_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                              ACLK,
  input  logic                              ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic                              PWM_OUT
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = C_S_AXI_DATA_WIDTH / 8;
  localparam logic [DW-1:0] CNT_ONE = DW'(1);

  logic [DW-1:0] regs [4];

  // write channel state
  logic          aw_full, w_full, bvalid_q, awready_q, wready_q;
  logic [1:0]    aw_idx_q;
  logic [DW-1:0] wdata_q;
  logic [SW-1:0] wstrb_q;

  // read channel state
  logic          rvalid_q, arready_q;
  logic [DW-1:0] rdata_q;

  // PWM state
  logic [DW-1:0] cnt, sh_period, sh_duty;
  logic          pwm_q;

  // next-state helpers
  logic          aw_hs, w_hs, aw_have, w_have, commit;
  logic          aw_full_nxt, w_full_nxt, bvalid_nxt;
  logic [1:0]    wr_idx;
  logic [DW-1:0] wr_data;
  logic [SW-1:0] wr_strb;
  logic          ar_hs, rvalid_nxt;
  logic          en, pol, raw;

  // A handshake in the current cycle counts as "held" so that AW+W in
  // cycle N commits at the end of N and BVALID shows in N+1.
  always_comb begin
    aw_hs       = S_AXI_AWVALID && awready_q;
    w_hs        = S_AXI_WVALID && wready_q;
    aw_have     = aw_full || aw_hs;
    w_have      = w_full || w_hs;
    wr_idx      = aw_full ? aw_idx_q : S_AXI_AWADDR[3:2];
    wr_data     = w_full ? wdata_q : S_AXI_WDATA;
    wr_strb     = w_full ? wstrb_q : S_AXI_WSTRB;
    commit      = aw_have && w_have;
    bvalid_nxt  = commit || (bvalid_q && !S_AXI_BREADY);
    aw_full_nxt = aw_have && !commit;
    w_full_nxt  = w_have && !commit;
    ar_hs       = S_AXI_ARVALID && arready_q;
    rvalid_nxt  = ar_hs || (rvalid_q && !S_AXI_RREADY);
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      for (int unsigned i = 0; i < 4; i++) regs[i] <= '0;
      aw_full   <= 1'b0;
      w_full    <= 1'b0;
      bvalid_q  <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      aw_idx_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      aw_full   <= aw_full_nxt;
      w_full    <= w_full_nxt;
      bvalid_q  <= bvalid_nxt;
      awready_q <= !aw_full_nxt && !bvalid_nxt;
      wready_q  <= !w_full_nxt && !bvalid_nxt;
      if (aw_hs) aw_idx_q <= S_AXI_AWADDR[3:2];
      if (w_hs) begin
        wdata_q <= S_AXI_WDATA;
        wstrb_q <= S_AXI_WSTRB;
      end
      if (commit) begin
        for (int unsigned b = 0; b < SW; b++) begin
          if (wr_strb[b]) regs[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
      rvalid_q  <= rvalid_nxt;
      arready_q <= !rvalid_nxt;
      // non-blocking read of regs returns the pre-commit value on a collision
      if (ar_hs) rdata_q <= regs[S_AXI_ARADDR[3:2]];
    end
  end

  always_comb begin
    en  = regs[0][0];
    pol = regs[0][1];
    raw = (sh_period != '0) && (cnt < sh_duty);
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      cnt       <= '0;
      sh_period <= '0;
      sh_duty   <= '0;
      pwm_q     <= 1'b0;
    end else if (!en) begin
      cnt       <= '0;
      sh_period <= regs[1];
      sh_duty   <= regs[2];
      pwm_q     <= pol;
    end else begin
      if (sh_period == '0 || cnt == sh_period - CNT_ONE) begin
        cnt       <= '0;
        sh_period <= regs[1];
        sh_duty   <= regs[2];
      end else begin
        cnt <= cnt + CNT_ONE;
      end
      pwm_q <= raw ^ pol;
    end
  end

  logic unused_inputs;
  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;
  assign PWM_OUT       = pwm_q;

endmodule

// File: tb/tb_pwm_axil_regs.sv
// tb_pwm_axil_regs: directed + randomized bench for pwm_axil_regs.
// Register contents are tracked in a byte-lane model array; the PWM pin is
// predicted arithmetically from period/duty/polarity and the edge at which
// the enabling CTRL write committed.
module tb_pwm_axil_regs;

  localparam int HMAX = 20000;
  localparam int NEVER = 32'h7fff_ffff;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic [3:0]  S_AXI_AWADDR = '0;
  logic [2:0]  S_AXI_AWPROT = '0;
  logic        S_AXI_AWVALID = 1'b0;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA = '0;
  logic [3:0]  S_AXI_WSTRB = '0;
  logic        S_AXI_WVALID = 1'b0;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY = 1'b0;
  logic [3:0]  S_AXI_ARADDR = '0;
  logic [2:0]  S_AXI_ARPROT = '0;
  logic        S_AXI_ARVALID = 1'b0;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY = 1'b0;
  logic        PWM_OUT;

  pwm_axil_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .PWM_OUT(PWM_OUT)
  );

  always #5 ACLK = ~ACLK;

  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  // pwm_hist[c] = PWM_OUT as left by rising edge number c
  logic pwm_hist [HMAX];
  always @(negedge ACLK) if (cyc < HMAX) pwm_hist[cyc] = PWM_OUT;

  int npass = 0;
  int ntotal = 0;
  logic [31:0] model [4];

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int b_dly, output int commit_edge);
    logic aw_done, w_done, aw_hs, w_hs;
    aw_done = 1'b0;
    w_done  = 1'b0;
    S_AXI_AWADDR = addr;
    S_AXI_WDATA  = data;
    S_AXI_WSTRB  = strb;
    for (int t = 0; t < 64 && !(aw_done && w_done); t++) begin
      S_AXI_AWVALID = !aw_done && (t >= aw_dly);
      S_AXI_WVALID  = !w_done && (t >= w_dly);
      aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
      w_hs  = S_AXI_WVALID && S_AXI_WREADY;
      tick();
      if (aw_hs) aw_done = 1'b1;
      if (w_hs)  w_done  = 1'b1;
    end
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    check("wr_handshake", {63'd0, aw_done && w_done}, 64'd1);
    commit_edge = cyc;
    check("bvalid_latency", {63'd0, S_AXI_BVALID}, 64'd1);
    check("bresp", {62'd0, S_AXI_BRESP}, 64'd0);
    for (int i = 0; i < b_dly; i++) begin
      tick();
      check("bvalid_hold", {63'd0, S_AXI_BVALID}, 64'd1);
      check("awready_blocked", {63'd0, S_AXI_AWREADY}, 64'd0);
    end
    S_AXI_BREADY = 1'b1;
    tick();
    S_AXI_BREADY = 1'b0;
    check("bvalid_clear", {63'd0, S_AXI_BVALID}, 64'd0);
    for (int b = 0; b < 4; b++)
      if (strb[b]) model[addr[3:2]][8*b +: 8] = data[8*b +: 8];
  endtask

  task automatic axi_read(input logic [3:0] addr, input int r_dly, output logic [31:0] data);
    logic done, hs;
    done = 1'b0;
    S_AXI_ARADDR  = addr;
    S_AXI_ARVALID = 1'b1;
    for (int t = 0; t < 64 && !done; t++) begin
      hs = S_AXI_ARREADY;
      tick();
      if (hs) done = 1'b1;
    end
    S_AXI_ARVALID = 1'b0;
    check("rd_handshake", {63'd0, done}, 64'd1);
    check("rvalid_latency", {63'd0, S_AXI_RVALID}, 64'd1);
    check("rresp", {62'd0, S_AXI_RRESP}, 64'd0);
    data = S_AXI_RDATA;
    check("rdata_model", {32'd0, data}, {32'd0, model[addr[3:2]]});
    for (int i = 0; i < r_dly; i++) begin
      tick();
      check("rvalid_hold", {63'd0, S_AXI_RVALID}, 64'd1);
      check("rdata_hold", {32'd0, S_AXI_RDATA}, {32'd0, data});
    end
    S_AXI_RREADY = 1'b1;
    tick();
    S_AXI_RREADY = 1'b0;
  endtask

  // Period k starts with the shadow reload at edge e+k*P; a DUTY write that
  // committed at edge w is only seen by reloads strictly after w.
  function automatic logic pwm_expect(input int c, input int e, input int p, input int d0,
                                      input int w, input int d1, input logic pol);
    int i, k, d;
    if (p == 0) return pol;
    i = c - e - 1;
    k = i / p;
    d = (e + k * p > w) ? d1 : d0;
    return pol ^ ((i % p) < d);
  endfunction

  task automatic pwm_window(input string tag, input int c0, input int c1, input int e, input int p,
                            input int d0, input int w, input int d1, input logic pol);
    while (cyc <= c1) tick();
    for (int c = c0; c <= c1; c++)
      check(tag, {63'd0, pwm_hist[c]}, {63'd0, pwm_expect(c, e, p, d0, w, d1, pol)});
  endtask

  task automatic pwm_setup(input int p, input int d, input logic pol, output int e);
    int x;
    axi_write(4'h0, 32'h0, 4'hF, 0, 0, 0, x);
    axi_write(4'h4, p, 4'hF, 0, 0, 0, x);
    axi_write(4'h8, d, 4'hF, 0, 0, 0, x);
    axi_write(4'h0, {30'd0, pol, 1'b1}, 4'hF, 0, 0, 0, e);
  endtask

  initial begin
    logic [31:0] rd;
    int e, w, p, d;
    logic pol;
    for (int i = 0; i < 4; i++) model[i] = '0;

    // reset state
    repeat (2) tick();
    check("rst_awready", {63'd0, S_AXI_AWREADY}, 64'd0);
    check("rst_wready", {63'd0, S_AXI_WREADY}, 64'd0);
    check("rst_arready", {63'd0, S_AXI_ARREADY}, 64'd0);
    check("rst_bvalid", {63'd0, S_AXI_BVALID}, 64'd0);
    check("rst_rvalid", {63'd0, S_AXI_RVALID}, 64'd0);
    check("rst_rdata", {32'd0, S_AXI_RDATA}, 64'd0);
    check("rst_pwm", {63'd0, PWM_OUT}, 64'd0);
    ARESET = 1'b0;
    tick();

    // basic write/readback
    for (int i = 0; i < 4; i++) axi_write(4'(i * 4), 32'(i + 1), 4'hF, 0, 0, 0, w);
    for (int i = 0; i < 4; i++) begin
      axi_read(4'(i * 4), 0, rd);
      check("basic_rd", {32'd0, rd}, 64'(i + 1));
    end

    // W before AW, then AW before W, each with a stalled B channel
    axi_write(4'h8, 32'h0000_0055, 4'hF, 3, 0, 5, w);
    axi_read(4'h8, 0, rd);
    check("w_first", {32'd0, rd}, 64'h55);
    axi_write(4'h4, 32'h0000_0066, 4'hF, 0, 3, 5, w);
    axi_read(4'h4, 2, rd);
    check("aw_first", {32'd0, rd}, 64'h66);

    // byte strobes
    axi_write(4'hC, 32'hAABB_CCDD, 4'hF, 0, 0, 0, w);
    axi_write(4'hC, 32'h1122_3344, 4'b0101, 0, 0, 0, w);
    axi_read(4'hC, 0, rd);
    check("strb_merge", {32'd0, rd}, 64'hAA22_CC44);

    // randomized register traffic, aliased low address bits
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 1) == 1)
        axi_write(4'($urandom), $urandom, 4'($urandom_range(0, 15)),
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), w);
      else
        axi_read(4'($urandom), $urandom_range(0, 2), rd);
    end

    // PWM 10/3, then DUTY=7 mid-period
    pwm_setup(10, 3, 1'b0, e);
    for (int t = 0; t < 64 && ((cyc - e - 1) % 10) != 4; t++) tick();
    axi_write(4'h8, 32'd7, 4'hF, 0, 0, 0, w);
    pwm_window("pwm_duty_change", e + 1, e + 41, e, 10, 3, w, 7, 1'b0);
    check("pwm_first_high", {63'd0, pwm_hist[e + 3]}, 64'd1);
    check("pwm_first_low", {63'd0, pwm_hist[e + 4]}, 64'd0);

    // boundaries
    pwm_setup(0, 5, 1'b0, e);
    pwm_window("pwm_period0", e + 1, e + 30, e, 0, 5, NEVER, 5, 1'b0);
    pwm_setup(10, 12, 1'b0, e);
    pwm_window("pwm_duty_ge_period", e + 1, e + 30, e, 10, 12, NEVER, 12, 1'b0);
    pwm_setup(10, 0, 1'b1, e);
    pwm_window("pwm_duty0_inv", e + 1, e + 30, e, 10, 0, NEVER, 0, 1'b1);

    // randomized PWM settings
    for (int n = 0; n < 4; n++) begin
      p = $urandom_range(1, 12);
      d = $urandom_range(0, 14);
      pol = 1'($urandom_range(0, 1));
      pwm_setup(p, d, pol, e);
      pwm_window("pwm_random", e + 1, e + 3 * p + 5, e, p, d, NEVER, d, pol);
    end

    // reset with a read response and a write response both pending
    S_AXI_ARADDR  = 4'h4;
    S_AXI_ARVALID = 1'b1;
    for (int t = 0; t < 64 && !S_AXI_ARREADY; t++) tick();
    tick();
    S_AXI_ARVALID = 1'b0;
    S_AXI_AWADDR  = 4'hC;
    S_AXI_WDATA   = 32'h1234_5678;
    S_AXI_WSTRB   = 4'hF;
    S_AXI_AWVALID = 1'b1;
    S_AXI_WVALID  = 1'b1;
    for (int t = 0; t < 64 && !(S_AXI_AWREADY && S_AXI_WREADY); t++) tick();
    tick();
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    check("pre_rst_rvalid", {63'd0, S_AXI_RVALID}, 64'd1);
    check("pre_rst_bvalid", {63'd0, S_AXI_BVALID}, 64'd1);
    ARESET = 1'b1;
    tick();
    check("mid_rst_rvalid", {63'd0, S_AXI_RVALID}, 64'd0);
    check("mid_rst_bvalid", {63'd0, S_AXI_BVALID}, 64'd0);
    check("mid_rst_pwm", {63'd0, PWM_OUT}, 64'd0);
    check("mid_rst_rdata", {32'd0, S_AXI_RDATA}, 64'd0);
    ARESET = 1'b0;
    for (int i = 0; i < 4; i++) model[i] = '0;
    tick();
    for (int i = 0; i < 4; i++) begin
      axi_read(4'(i * 4), 0, rd);
      check("post_rst_rd", {32'd0, rd}, 64'd0);
    end
    check("post_rst_pwm", {63'd0, PWM_OUT}, 64'd0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
